// File: rtl/byte_serializer_if.sv
// Parallel-in / serial-out handshake bundle for byte_serializer.
interface byte_serializer_if;
  logic [7:0] byte_in;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       bit_out;
  logic       bit_valid;
  logic       first_bit;
  logic       byte_done;
  logic       busy;

  modport master (
    output byte_in, in_valid, flush,
    input  in_ready, bit_out, bit_valid, first_bit, byte_done, busy
  );

  modport slave (
    input  byte_in, in_valid, flush,
    output in_ready, bit_out, bit_valid, first_bit, byte_done, busy
  );
endinterface

// File: rtl/byte_serializer.sv
// MSB-first byte serializer with a shifter plus one pending byte.
// Define BYTE_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module byte_serializer (
  input  logic              clk,
  input  logic              rst,
  byte_serializer_if.slave  bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef BYTE_SERIALIZER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;
  logic [BYTE_W-1:0] pend;
  logic              pend_full;
  logic              bit_out_q;
  logic              bit_valid_q;
  logic              first_bit_q;
  logic              byte_done_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  logic              accept;
  logic              last_bit;
  logic              start_pend;
  logic              start_in;
  logic              start;
  logic [BYTE_W-1:0] start_byte;

  assign bus.in_ready = !pend_full && !bus.flush && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Frame-end detection and selection of the next byte to start
  always_comb begin
    last_bit = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
    if (state == PARITY) last_bit = 1'b1;
`else
    if ((state == SHIFT) && (cnt == CNT_W'(7))) last_bit = 1'b1;
`endif
    start_pend = last_bit && pend_full;
    start_in   = accept && ((state == IDLE) || (last_bit && !pend_full));
    start      = start_pend || start_in;
    start_byte = pend_full ? pend : bus.byte_in;
  end

  // sh holds the bits still to be sent, left-aligned; bit_out holds the current one
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      first_bit_q <= 1'b0;
      byte_done_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (start) begin
        state       <= SHIFT;
        sh          <= {start_byte[BYTE_W-2:0], 1'b0};
        cnt         <= '0;
        bit_out_q   <= start_byte[BYTE_W-1];
        bit_valid_q <= 1'b1;
        first_bit_q <= 1'b1;
        byte_done_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
        par_q       <= ^start_byte;
`endif
      end else if ((state == SHIFT) && (cnt != CNT_W'(7))) begin
        sh          <= {sh[BYTE_W-2:0], 1'b0};
        cnt         <= cnt + CNT_W'(1);
        bit_out_q   <= sh[BYTE_W-1];
        bit_valid_q <= 1'b1;
        first_bit_q <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
        byte_done_q <= 1'b0;
`else
        byte_done_q <= (cnt == CNT_W'(6));
`endif
      end
`ifdef BYTE_SERIALIZER_PARITY_EN
      else if (state == SHIFT) begin
        state       <= PARITY;
        bit_out_q   <= par_q;
        bit_valid_q <= 1'b1;
        first_bit_q <= 1'b0;
        byte_done_q <= 1'b1;
      end
`endif
      else if (last_bit) begin
        state       <= IDLE;
        sh          <= '0;
        cnt         <= '0;
        bit_out_q   <= 1'b0;
        bit_valid_q <= 1'b0;
        first_bit_q <= 1'b0;
        byte_done_q <= 1'b0;
      end

      // Pending slot: refill on accept unless the byte went straight to the shifter
      if (accept && !start_in) begin
        pend      <= bus.byte_in;
        pend_full <= 1'b1;
      end else if (start_pend) begin
        pend_full <= 1'b0;
      end
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.first_bit = first_bit_q;
  assign bus.byte_done = byte_done_q;
  assign bus.busy      = (state != IDLE) || pend_full;

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: directed scenarios then random traffic.
module tb_byte_serializer;

`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  byte_serializer_if bus();

  byte_serializer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic first;
    logic done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int         pos = 0;
  int         checks = 0;
  int         errors = 0;
  bit         acc_flag = 1'b0;

  function automatic void push_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.b     = b[7-i];
      e.first = (i == 0);
      e.done  = (i == 7) && (FRAME == 8);
      exp_q.push_back(e);
    end
`ifdef BYTE_SERIALIZER_PARITY_EN
    begin
      exp_t p;
      p.b = ^b; p.first = 1'b0; p.done = 1'b1;
      exp_q.push_back(p);
    end
`endif
  endfunction

  // Reference model: bytes in flight as a queue, position within the front frame
  always @(posedge clk) begin
    bit exp_ready;
    bit acc;
    exp_ready = (model_q.size() < 2) && !bus.flush && !rst;
    checks++;
    if (bus.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", bus.in_ready, exp_ready, $time);
    end
    acc = bus.in_valid && exp_ready;
    acc_flag = acc;
    if (rst || bus.flush) begin
      model_q.delete();
      exp_q.delete();
      pos = 0;
    end else begin
      if (model_q.size() > 0) begin
        pos++;
        if (pos == FRAME) begin
          void'(model_q.pop_front());
          pos = 0;
        end
      end
      if (acc) begin
        model_q.push_back(bus.byte_in);
        push_bits(bus.byte_in);
      end
    end
  end

  // Monitor: pops an expected bit whenever the DUT presents one
  always @(posedge clk) begin
    exp_t e;
    bit   exp_active;
    #1;
    exp_active = (model_q.size() > 0);
    checks++;
    if (bus.bit_valid !== exp_active) begin
      errors++;
      $display("FAIL bit_valid: got %b expected %b at %0t", bus.bit_valid, exp_active, $time);
    end
    checks++;
    if (bus.busy !== exp_active) begin
      errors++;
      $display("FAIL busy: got %b expected %b at %0t", bus.busy, exp_active, $time);
    end
    if (bus.bit_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit: got bit_out=%b with nothing expected at %0t", bus.bit_out, $time);
      end else begin
        e = exp_q.pop_front();
        if ({bus.bit_out, bus.first_bit, bus.byte_done} !== e) begin
          errors++;
          $display("FAIL bit{out,first,done}: got %b%b%b expected %b%b%b at %0t",
                   bus.bit_out, bus.first_bit, bus.byte_done, e.b, e.first, e.done, $time);
        end
      end
    end else begin
      checks++;
      if ({bus.bit_out, bus.first_bit, bus.byte_done} !== 3'b000) begin
        errors++;
        $display("FAIL idle_outputs: got %b%b%b expected 000 at %0t",
                 bus.bit_out, bus.first_bit, bus.byte_done, $time);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.byte_in  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_flag && n < 64);
    checks++;
    if (!acc_flag) begin
      errors++;
      $display("FAIL accept_timeout: byte %h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.byte_in  = 8'h00;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    send(8'hA5);
    idle(12);

    send(8'h3C);
    send(8'hF0);
    idle(22);

    // Flush while the 4th bit of 0xFF is on the line, 0x81 pending
    send(8'hFF);
    send(8'h81);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.byte_in  = 8'h55;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    idle(3);
    send(8'h81);
    idle(12);

    // Reset while the 5th bit of 0xAA is on the line
    send(8'hAA);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(32);

    repeat (600) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.byte_in  = 8'($urandom);
      bus.flush    = ($urandom_range(0, 49) == 0);
      rst          = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    rst       = 1'b0;
    idle(30);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected bits never emitted, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on posedge clk only.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 byte_in  input  8  parallel byte to transmit.
REQ-005 in_valid  input  1  byte_in holds a byte offered for transmission.
REQ-006 in_ready  output  1  block accepts byte_in this cycle; transfer occurs on a clock edge where in_valid && in_ready.
REQ-007 flush  input  1  synchronous abort: discard the in-flight byte and the pending byte.
REQ-008 bit_out  output  1  current serial bit, MSB first.
REQ-009 bit_valid  output  1  bit_out carries a payload or parity bit this cycle.
REQ-010 first_bit  output  1  high while bit_out carries bit 7 of a byte.
REQ-011 byte_done  output  1  high while bit_out carries the last bit of a byte.
REQ-012 busy  output  1  high when the shifter or the pending register is occupied.

Function
REQ-013 Storage SHALL be an 8-bit shift register plus a 1-entry pending register, giving at most 2 bytes in flight.
REQ-014 State machine: IDLE (shifter empty), SHIFT (payload bits), PARITY (exists only with PARITY_EN).
REQ-015 in_ready SHALL equal !pending_full && !flush && !rst.
REQ-016 Accept in IDLE: the byte SHALL load directly into the shifter; bit 7 appears on bit_out the next cycle (latency 1) with bit_valid=1 and first_bit=1.
REQ-017 Accept in SHIFT/PARITY: the byte SHALL go to the pending register.
REQ-018 SHIFT: emit one bit per cycle, MSB first, with a 3-bit counter running 0..7; bit k of the frame = byte[7-k].
REQ-019 Last frame bit (counter 7 without parity, or PARITY state): byte_done=1. At that edge, load the shifter from pending if full; otherwise from byte_in if accepted that same edge. The next byte then starts in the following cycle with no idle gap. If neither source has a byte, go to IDLE.
REQ-020 Simultaneous pop of pending and a new accept: pending SHALL be refilled with byte_in on the same edge; no byte is lost or duplicated.
REQ-021 In IDLE, bit_valid, first_bit and byte_done SHALL be 0 and bit_out SHALL be 0.
REQ-022 busy SHALL equal (state!=IDLE) || pending_full.
REQ-023 flush=1 SHALL clear the shifter, counter and pending register and move to IDLE on that edge; the partially sent byte is dropped; a byte offered that cycle is not accepted.
REQ-024 Flush asserted for multiple cycles SHALL hold the block in IDLE with in_ready=0.
REQ-025 Byte order SHALL be strictly FIFO: acceptance order equals transmission order.

Reset
REQ-026 rst SHALL take priority over flush and in_valid.
REQ-027 On reset: state=IDLE, counter=0, shifter=0, pending empty, bit_out=0, bit_valid=0, first_bit=0, byte_done=0, busy=0; in_ready=0 during reset and 1 on the first cycle after it.
REQ-028 Reset mid-byte SHALL abandon the byte with no further bit_valid cycles.

Configuration
REQ-029 Macro BYTE_SERIALIZER_PARITY_EN defined: after bit 0, a PARITY state emits even parity (XOR of the 8 payload bits) with bit_valid=1 and byte_done=1. Frame = 9 cycles.
REQ-030 Macro not defined: no PARITY state, byte_done on bit 0, frame = 8 cycles; the port list SHALL be identical in both builds.

Verification
REQ-031 Single byte 0xA5 accepted in IDLE -> bit_out 1,0,1,0,0,1,0,1 on the 8 following cycles; first_bit on cycle 1, byte_done on cycle 8, then IDLE and busy=0.
REQ-032 Back-to-back 0x3C then 0xF0, both with in_valid held -> 16 consecutive bit_valid cycles 00111100 11110000; in_ready drops while pending is full; no gap between the two bytes.
REQ-033 flush on the 4th bit of 0xFF, with 0x81 pending -> no further bit_valid; 0x81 is never sent; busy=0 the next cycle; a subsequent 0x81 is sent intact.
REQ-034 rst on the 5th bit of 0xAA -> all outputs at reset values the next cycle; in_ready=1 the cycle after.
REQ-035 PARITY_EN build, byte 0x07 -> bits 0,0,0,0,0,1,1,1 then parity 1 with byte_done; byte 0xA5 -> parity 0.
REQ-036 Pop and refill on the same edge: 3 bytes 0x11,0x22,0x33 streamed with in_valid held -> 24 contiguous bits in order.
